// File: rtl/viterbi_ber_monitor.sv
// Receive-side BER monitor: searches the decoder latency against a reference history, then counts
// checked bits and residual errors. Define VITERBI_BER_FIRST_ERR_EN to add first-error capture.
module viterbi_ber_monitor #(
   parameter int unsigned MAX_LAT  = 64,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned LOCK_RUN = 32,
   parameter int unsigned WIN      = 64,
   parameter int unsigned LOSE_ERR = 8,
   localparam int unsigned LAT_W   = $clog2(MAX_LAT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ref_valid_i,
   input  logic             ref_bit_i,
   input  logic             dec_valid_i,
   input  logic             dec_bit_i,
   input  logic             clear_i,
   output logic             locked_o,
   output logic [LAT_W-1:0] latency_o,
   output logic [CNT_W-1:0] bit_ct_o,
   output logic [CNT_W-1:0] err_ct_o,
   output logic             overflow_o
`ifdef VITERBI_BER_FIRST_ERR_EN
   ,
   output logic [CNT_W-1:0] first_err_o,
   output logic             first_err_vld_o
`endif
);

   localparam int unsigned RUN_W  = $clog2(LOCK_RUN + 1);
   localparam int unsigned WCT_W  = $clog2(WIN + 1);
   localparam int unsigned WERR_W = $clog2(LOSE_ERR + 1);

   typedef enum logic [0:0] {StSearch, StLocked} state_e;

   state_e              state_q, state_d;
   logic [MAX_LAT-1:0]  hist_q, hist_d;
   logic [LAT_W-1:0]    k_q, k_d;
   logic [RUN_W-1:0]    run_q, run_d, run_inc;
   logic [WCT_W-1:0]    win_ct_q, win_ct_d, win_ct_inc;
   logic [WERR_W-1:0]   win_err_q, win_err_d, win_err_inc;
   logic [CNT_W-1:0]    bit_ct_q, bit_ct_d;
   logic [CNT_W-1:0]    err_ct_q, err_ct_d;
   logic                ovf_q, ovf_d;
   logic                match;
`ifdef VITERBI_BER_FIRST_ERR_EN
   logic [CNT_W-1:0]    first_err_q, first_err_d;
   logic                first_vld_q, first_vld_d;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Compare against the pre-shift history, even when a new reference bit arrives this cycle.
   assign match       = (dec_bit_i == hist_q[k_q]);
   assign run_inc     = run_q + RUN_W'(1);
   assign win_ct_inc  = win_ct_q + WCT_W'(1);
   assign win_err_inc = match ? win_err_q : win_err_q + WERR_W'(1);

   always_comb begin
      state_d   = state_q;
      hist_d    = hist_q;
      k_d       = k_q;
      run_d     = run_q;
      win_ct_d  = win_ct_q;
      win_err_d = win_err_q;
      bit_ct_d  = bit_ct_q;
      err_ct_d  = err_ct_q;
`ifdef VITERBI_BER_FIRST_ERR_EN
      first_err_d = first_err_q;
      first_vld_d = first_vld_q;
`endif

      if (ref_valid_i) begin
         hist_d = {hist_q[MAX_LAT-2:0], ref_bit_i};
      end

      if (dec_valid_i) begin
         unique case (state_q)
            StSearch: begin
               if (match) begin
                  if (run_inc == RUN_W'(LOCK_RUN)) begin
                     state_d   = StLocked;
                     run_d     = '0;
                     win_ct_d  = '0;
                     win_err_d = '0;
                  end else begin
                     run_d = run_inc;
                  end
               end else begin
                  run_d = '0;
                  k_d   = k_q + LAT_W'(1);
               end
            end
            StLocked: begin
               bit_ct_d = sat_inc(bit_ct_q);
               if (!match) begin
                  err_ct_d = sat_inc(err_ct_q);
`ifdef VITERBI_BER_FIRST_ERR_EN
                  if (!first_vld_q) begin
                     first_err_d = bit_ct_q;
                     first_vld_d = 1'b1;
                  end
`endif
               end
               // Loss of lock outranks the window rollover on the same bit.
               if (!match && win_err_inc == WERR_W'(LOSE_ERR)) begin
                  state_d   = StSearch;
                  k_d       = k_q + LAT_W'(1);
                  run_d     = '0;
                  win_ct_d  = '0;
                  win_err_d = '0;
               end else if (win_ct_inc == WCT_W'(WIN)) begin
                  win_ct_d  = '0;
                  win_err_d = match ? WERR_W'(0) : WERR_W'(1);
               end else begin
                  win_ct_d  = win_ct_inc;
                  win_err_d = win_err_inc;
               end
            end
            default: state_d = StSearch;
         endcase
      end

      ovf_d = ovf_q | (&bit_ct_d) | (&err_ct_d);

      if (clear_i) begin
         bit_ct_d = '0;
         err_ct_d = '0;
         ovf_d    = 1'b0;
`ifdef VITERBI_BER_FIRST_ERR_EN
         first_err_d = '0;
         first_vld_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StSearch;
         hist_q    <= '0;
         k_q       <= '0;
         run_q     <= '0;
         win_ct_q  <= '0;
         win_err_q <= '0;
         bit_ct_q  <= '0;
         err_ct_q  <= '0;
         ovf_q     <= 1'b0;
`ifdef VITERBI_BER_FIRST_ERR_EN
         first_err_q <= '0;
         first_vld_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         hist_q    <= hist_d;
         k_q       <= k_d;
         run_q     <= run_d;
         win_ct_q  <= win_ct_d;
         win_err_q <= win_err_d;
         bit_ct_q  <= bit_ct_d;
         err_ct_q  <= err_ct_d;
         ovf_q     <= ovf_d;
`ifdef VITERBI_BER_FIRST_ERR_EN
         first_err_q <= first_err_d;
         first_vld_q <= first_vld_d;
`endif
      end
   end

   assign locked_o   = (state_q == StLocked);
   assign latency_o  = k_q;
   assign bit_ct_o   = bit_ct_q;
   assign err_ct_o   = err_ct_q;
   assign overflow_o = ovf_q;
`ifdef VITERBI_BER_FIRST_ERR_EN
   assign first_err_o     = first_err_q;
   assign first_err_vld_o = first_vld_q;
`endif

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// Bench for viterbi_ber_monitor: a default instance and a CNT_W=4 instance share random stimulus
// and are checked every cycle against a queue-based reference model.
module tb_viterbi_ber_monitor;

   localparam int MAX_LAT  = 64;
   localparam int LOCK_RUN = 32;
   localparam int WIN      = 64;
   localparam int LOSE_ERR = 8;
   localparam int W_A      = 16;
   localparam int W_B      = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ref_valid = 1'b0, ref_bit = 1'b0, dec_valid = 1'b0, dec_bit = 1'b0, clear = 1'b0;

   logic           a_locked, b_locked, a_ovf, b_ovf;
   logic [5:0]     a_lat, b_lat;
   logic [W_A-1:0] a_bits, a_errs;
   logic [W_B-1:0] b_bits, b_errs;
`ifdef VITERBI_BER_FIRST_ERR_EN
   logic [W_A-1:0] a_fe;
   logic [W_B-1:0] b_fe;
   logic           a_fv, b_fv;
`endif

   always #5 clk = ~clk;

   viterbi_ber_monitor dut_a (
      .clk         (clk),
      .rst         (rst),
      .ref_valid_i (ref_valid),
      .ref_bit_i   (ref_bit),
      .dec_valid_i (dec_valid),
      .dec_bit_i   (dec_bit),
      .clear_i     (clear),
      .locked_o    (a_locked),
      .latency_o   (a_lat),
      .bit_ct_o    (a_bits),
      .err_ct_o    (a_errs),
      .overflow_o  (a_ovf)
`ifdef VITERBI_BER_FIRST_ERR_EN
      ,
      .first_err_o     (a_fe),
      .first_err_vld_o (a_fv)
`endif
   );

   viterbi_ber_monitor #(.CNT_W(W_B)) dut_b (
      .clk         (clk),
      .rst         (rst),
      .ref_valid_i (ref_valid),
      .ref_bit_i   (ref_bit),
      .dec_valid_i (dec_valid),
      .dec_bit_i   (dec_bit),
      .clear_i     (clear),
      .locked_o    (b_locked),
      .latency_o   (b_lat),
      .bit_ct_o    (b_bits),
      .err_ct_o    (b_errs),
      .overflow_o  (b_ovf)
`ifdef VITERBI_BER_FIRST_ERR_EN
      ,
      .first_err_o     (b_fe),
      .first_err_vld_o (b_fv)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: newest reference bit at the front of m_hist; counts kept unsaturated.
   bit     m_hist[$];
   bit     m_locked;
   int     m_k, m_run, m_wn, m_we;
   longint m_bits, m_errs, m_fe;
   bit     m_fv;

   bit     sent[$];
   int     lat_d = 0;

   function automatic longint satv(input longint v, input int w);
      longint mx = (longint'(1) << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   function automatic bit ovf_exp(input int w);
      longint mx = (longint'(1) << w) - 1;
      return (m_bits >= mx) || (m_errs >= mx);
   endfunction

   function automatic bit ref_at(input int k);
      return (k < m_hist.size()) ? m_hist[k] : 1'b0;
   endfunction

   task automatic model_reset();
      m_hist.delete();
      sent.delete();
      m_locked = 1'b0;
      m_k = 0; m_run = 0; m_wn = 0; m_we = 0;
      m_bits = 0; m_errs = 0; m_fe = 0; m_fv = 1'b0;
   endtask

   task automatic model_step();
      bit mm;
      if (dec_valid) begin
         mm = (dec_bit != ref_at(m_k));
         if (!m_locked) begin
            if (!mm) begin
               m_run++;
               if (m_run == LOCK_RUN) begin
                  m_locked = 1'b1;
                  m_run = 0; m_wn = 0; m_we = 0;
               end
            end else begin
               m_run = 0;
               m_k = (m_k + 1) % MAX_LAT;
            end
         end else begin
            if (!clear) begin
               if (mm && !m_fv) begin
                  m_fv = 1'b1;
                  m_fe = m_bits;
               end
               m_bits++;
               if (mm) m_errs++;
            end
            m_wn++;
            if (mm) m_we++;
            if (mm && m_we >= LOSE_ERR) begin
               m_locked = 1'b0;
               m_k = (m_k + 1) % MAX_LAT;
               m_run = 0; m_wn = 0; m_we = 0;
            end else if (m_wn == WIN) begin
               m_wn = 0;
               m_we = mm ? 1 : 0;
            end
         end
      end
      if (clear) begin
         m_bits = 0; m_errs = 0; m_fe = 0; m_fv = 1'b0;
      end
      if (ref_valid) begin
         m_hist.push_front(ref_bit);
         if (m_hist.size() > MAX_LAT) void'(m_hist.pop_back());
      end
   endtask

   task automatic compare_all();
      check("locked", 64'(a_locked), 64'(m_locked));
      check("latency", 64'(a_lat), 64'(m_k));
      check("bit_ct", 64'(a_bits), 64'(satv(m_bits, W_A)));
      check("err_ct", 64'(a_errs), 64'(satv(m_errs, W_A)));
      check("overflow", 64'(a_ovf), 64'(ovf_exp(W_A)));
      check("sat_locked", 64'(b_locked), 64'(m_locked));
      check("sat_latency", 64'(b_lat), 64'(m_k));
      check("sat_bit_ct", 64'(b_bits), 64'(satv(m_bits, W_B)));
      check("sat_err_ct", 64'(b_errs), 64'(satv(m_errs, W_B)));
      check("sat_overflow", 64'(b_ovf), 64'(ovf_exp(W_B)));
`ifdef VITERBI_BER_FIRST_ERR_EN
      check("first_vld", 64'(a_fv), 64'(m_fv));
      check("first_err", 64'(a_fe), m_fv ? 64'(satv(m_fe, W_A)) : 64'(0));
      check("sat_first_vld", 64'(b_fv), 64'(m_fv));
      check("sat_first_err", 64'(b_fe), m_fv ? 64'(satv(m_fe, W_B)) : 64'(0));
`endif
   endtask

   // Drives one cycle; the decoded bit is the reference stream delayed by lat_d bits.
   task automatic cycle(input bit rv, input bit dv, input bit flip, input bit clr);
      int idx;
      bit rb, db;
      rb  = 1'($urandom);
      idx = sent.size() - 1 - lat_d;
      db  = ((idx >= 0) ? sent[idx] : 1'b0) ^ flip;
      ref_valid = rv; ref_bit = rb; dec_valid = dv; dec_bit = db; clear = clr;
      @(posedge clk);
      model_step();
      if (rv) sent.push_back(rb);
      #1;
      compare_all();
   endtask

   task automatic run_until_lock(input string tag, input int budget);
      int n = 0;
      while (!a_locked && n < budget) begin
         cycle(1'b1, 1'b1, 1'b0, 1'b0);
         n++;
      end
      check(tag, 64'(a_locked), 64'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   longint rec_bits, rec_errs;
   bit     rv, dv, fl, clr;
   int     burst = 0;

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      #2 rst = 1'b1;

      // Lock at latency 0.
      lat_d = 0;
      repeat (LOCK_RUN - 1) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check("lock_early", 64'(a_locked), 64'(0));
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check("lock_rise", 64'(a_locked), 64'(1));
      check("lock_lat0", 64'(a_lat), 64'(0));
      repeat (100) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check("bits_100", 64'(a_bits), 64'(100));
      check("errs_0", 64'(a_errs), 64'(0));
      check("sat_bits_15", 64'(b_bits), 64'(15));
      check("sat_ovf_set", 64'(b_ovf), 64'(1));

      // Clear together with a decoded bit.
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      check("clr_bits", 64'(b_bits), 64'(0));
      check("clr_ovf", 64'(b_ovf), 64'(0));
      check("clr_locked", 64'(b_locked), 64'(1));

      // Asynchronous reset mid-cycle while locked.
      #2 rst = 1'b0;
      #1;
      model_reset();
      check("arst_locked", 64'(a_locked), 64'(0));
      check("arst_lat", 64'(a_lat), 64'(0));
      check("arst_bits", 64'(a_bits), 64'(0));
      check("arst_errs", 64'(a_errs), 64'(0));
      check("arst_ovf", 64'(b_ovf), 64'(0));
      @(posedge clk);
      #2 rst = 1'b1;

      // Lock at latency 13.
      lat_d = 13;
      run_until_lock("lock13", 400);
      check("lock13_lat", 64'(a_lat), 64'(13));
      repeat (50) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check("lock13_errs", 64'(a_errs), 64'(0));

      // One error every 16 bits over 256 bits.
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 256; i++) cycle(1'b1, 1'b1, (i % 16) == 15, 1'b0);
      check("inj_errs", 64'(a_errs), 64'(16));
      check("inj_bits", 64'(a_bits), 64'(256));
      check("inj_locked", 64'(a_locked), 64'(1));

      // First error at checked bit 40.
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      repeat (40) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check("fe_errs", 64'(a_errs), 64'(1));
`ifdef VITERBI_BER_FIRST_ERR_EN
      check("fe_40", 64'(a_fe), 64'(40));
      check("fe_vld", 64'(a_fv), 64'(1));
`endif

      // Loss of lock: 8 consecutive errors inside one window.
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < WIN && m_wn != 0; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      rec_bits = longint'(a_bits);
      rec_errs = longint'(a_errs);
      repeat (LOSE_ERR - 1) cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check("loss_early", 64'(a_locked), 64'(1));
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check("loss_fall", 64'(a_locked), 64'(0));
      check("loss_lat", 64'(a_lat), 64'(14));
      repeat (5) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check("loss_bits_hold", 64'(a_bits), 64'(rec_bits + 8));
      check("loss_errs_hold", 64'(a_errs), 64'(rec_errs + 8));
      run_until_lock("relock", 1000);
      check("relock_lat", 64'(a_lat), 64'(13));

      // Randomized traffic: gaps, error bursts, clears, and a latency change.
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) lat_d = $urandom_range(0, MAX_LAT - 1);
         rv = ($urandom_range(0, 9) < 8);
         dv = ($urandom_range(0, 49) == 0) ? 1'($urandom) : rv;
         if (burst > 0) begin
            fl = 1'b1;
            burst--;
         end else begin
            fl = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 299) == 0) burst = $urandom_range(4, 12);
         end
         clr = ($urandom_range(0, 249) == 0);
         cycle(rv, dv, fl, clr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/viterbi_ber_monitor.md
Name: viterbi_ber_monitor

Overview:
- Receive-side checker for the encoder -> error-injecting channel -> Viterbi decoder chain; the reader counterpart of the channel's error injector.
- Keeps a history of the transmitted reference bits.
- Searches for the decoder's latency in bits, then counts decoded bits and residual bit errors once aligned.
- Sits beside the tx/rx wrapper: ref_* is tapped at the encoder input, dec_* at the decoder output.

Parameters:
- MAX_LAT, 64: depth of the reference history. Searchable latency is 0..MAX_LAT-1, counted in reference bits. Must be a power of 2.
- CNT_W, 16: width of the bit and error counters.
- LOCK_RUN, 32: consecutive matches at one candidate latency required to lock.
- WIN, 64: size of the error-monitoring window, in decoded bits, while LOCKED.
- LOSE_ERR, 8: errors within one window that force loss of lock.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ref_valid_i  in  1  ref_bit_i is a new transmitted bit this cycle
- ref_bit_i  in  1  transmitted (pre-encoder) data bit
- dec_valid_i  in  1  dec_bit_i is a new decoded bit this cycle
- dec_bit_i  in  1  decoder output bit
- clear_i  in  1  synchronous clear of the counters and overflow_o
- locked_o  out  1  high while in LOCKED
- latency_o  out  $clog2(MAX_LAT)  current candidate latency, or the locked latency
- bit_ct_o  out  CNT_W  decoded bits checked while LOCKED
- err_ct_o  out  CNT_W  mismatches while LOCKED
- overflow_o  out  1  sticky; a counter hit saturation

Behaviour:
- Reset (rst low, async) sets every output and all internal state to 0: history, state = SEARCH, candidate k = 0, run counter, window counters.
- History: hist[0] is the newest reference bit. On ref_valid_i, hist shifts by one and ref_bit_i enters at hist[0]. The oldest bit is discarded.
- Compare rule: on dec_valid_i, dec_bit_i is compared with hist[latency_o]. If ref_valid_i is high in the same cycle, the compare uses the pre-shift history; the shift then happens at the clock edge.
- FSM states: SEARCH, LOCKED. The FSM advances only on cycles with dec_valid_i high.
- SEARCH, match: run++. When run reaches LOCK_RUN, go to LOCKED on the next edge. latency_o holds k. run, win_ct and win_err clear to 0.
- SEARCH, mismatch: run = 0 and k = k+1. After MAX_LAT-1, k wraps to 0.
- SEARCH, counters: bit_ct_o and err_ct_o do not change.
- LOCKED, every dec bit: bit_ct_o++ and win_ct++. On mismatch, err_ct_o++ and win_err++.
- LOCKED, window: when win_ct reaches WIN, both win_ct and win_err reset to 0 on that edge. If an error occurs on the same edge, win_err restarts at 1 (new window).
- LOCKED, loss of lock: if win_err reaches LOSE_ERR, go to SEARCH. k advances to latency+1 (mod MAX_LAT) and run = 0. bit_ct_o and err_ct_o hold their values.
- Lock latency: locked_o rises one clock after the LOCK_RUN-th matching decoded bit. It falls one clock after the LOSE_ERR-th error.
- Saturation: a counter at all-ones stays there. Reaching all-ones sets overflow_o, which is sticky until clear_i or reset.
- clear_i has priority over increments in the same cycle: bit_ct_o, err_ct_o and overflow_o become 0. The state, latency, history and window counters are unaffected.
- If dec_valid_i is low, no comparison or count occurs, regardless of the history contents.
- Bits checked before MAX_LAT reference bits have entered are compared against reset zeros; no special handling.
- Reset during LOCKED returns to SEARCH with k = 0 immediately (asynchronously).

Optional Feature:
- Macro: VITERBI_BER_FIRST_ERR_EN.
- When defined: adds output first_err_o [CNT_W-1:0] and output first_err_vld_o [1].
- On the first mismatch while LOCKED, the pre-increment value of bit_ct_o is captured into first_err_o and first_err_vld_o is set.
- Both hold until clear_i or reset, which return them to 0.
- When undefined: neither port nor its logic exists, and all other behaviour is identical.

Test Plan:
- Lock at latency 0: drive ref=dec with the same PRBS on both, valid every cycle, defaults. locked_o rises 1 clock after the 32nd decoded bit; latency_o=0; after 100 more bits, bit_ct_o=100 and err_ct_o=0.
- Lock at latency 13: dec stream is the ref stream delayed by 13 bits. latency_o steps 0..13 and then locks with latency_o=13; err_ct_o=0 after lock.
- Injected errors: after lock, flip 1 dec bit every 16 bits for 256 bits. err_ct_o=16, bit_ct_o=256, locked_o stays 1 (4 errors per 64-bit window < 8).
- Loss of lock: after lock, flip 8 consecutive dec bits. locked_o falls 1 clock after the 8th flip; latency_o = old+1; counters hold. With clean data the monitor re-locks at the old latency after wrapping.
- Saturation and clear: CNT_W=4, locked, 20 bits. bit_ct_o=15 and overflow_o=1. Then assert clear_i together with dec_valid_i: counters read 0 and overflow_o=0; locked_o is unchanged.
- Async reset mid-LOCKED: pull rst low mid-cycle. All outputs are 0 immediately; after release, lock is re-acquired from k=0. With VITERBI_BER_FIRST_ERR_EN, a first error at checked bit 40 gives first_err_o=40 and first_err_vld_o=1.
